// File: rtl/trng_pkg.sv
// trng_pkg
//   Shared definitions for the TRNG entropy collector: default parameter
//   values and the von Neumann pair-state encoding.
package trng_pkg;

  localparam int DEFAULT_WIDTH       = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_REP_LIMIT   = 32;
  localparam int REP_CNT_W           = 16;

  // Von Neumann pair state: first sample of a pair, if one is held.
  typedef enum logic [1:0] {
    PAIR_EMPTY = 2'd0,
    PAIR_HAVE0 = 2'd1,
    PAIR_HAVE1 = 2'd2
  } pair_e;

endpackage

// File: rtl/trng_collector_if.sv
// trng_collector_if
//   Valid/ready word channel out of the entropy collector.
//   valid : data holds an unconsumed word (driven by master)
//   ready : consumer accepts the word when valid && ready (driven by slave)
//   data  : WIDTH-bit collected word (driven by master)
interface trng_collector_if #(
  parameter int WIDTH = trng_pkg::DEFAULT_WIDTH
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/trng_sync.sv
// trng_sync
//   STAGES-flop synchroniser for an asynchronous level, plus a rising-edge
//   detect on the synchronised level.
//   clk, rst_n : clock, async active-low reset
//   d          : asynchronous input
//   level      : synchronised level
//   rise       : one-cycle pulse on a rising edge of level
module trng_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/trng_collector.sv
// trng_collector
//   Ring-oscillator TRNG entropy collector: synchronises raw bit and strobe,
//   samples on strobe rising edges, runs a repetition-count health test,
//   optionally von Neumann debiases, packs WIDTH-bit words and hands them out
//   over a valid/ready channel.
//   clk, rst_n   : clock, async active-low reset
//   raw_in       : raw entropy bit (async)
//   strobe_in    : sampling strobe (async)
//   enable       : 1 = collect, 0 = idle and flush partial state
//   debias_en    : 1 = von Neumann debiasing
//   clear_err    : pulse clears health_fail, overrun and repetition count
//   out_if       : word channel (master side)
//   health_fail  : sticky repetition-count failure
//   overrun      : sticky, a completed word was dropped
//
// Pair FSM states:
//   state      | meaning
//   PAIR_EMPTY | no first sample held
//   PAIR_HAVE0 | first sample of pair was 0
//   PAIR_HAVE1 | first sample of pair was 1
module trng_collector
  import trng_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int REP_LIMIT   = DEFAULT_REP_LIMIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               raw_in,
  input  logic               strobe_in,
  input  logic               enable,
  input  logic               debias_en,
  input  logic               clear_err,
  trng_collector_if.master   out_if,
  output logic               health_fail,
  output logic               overrun
);

  localparam int CW = $clog2(WIDTH);

  logic raw_s, raw_edge_unused, strobe_rise;

  trng_sync #(.STAGES(SYNC_STAGES)) u_sync_strobe (
    .clk(clk), .rst_n(rst_n), .d(strobe_in), .level(), .rise(strobe_rise)
  );

  // Same depth as the strobe path so raw and strobe stay aligned.
  trng_sync #(.STAGES(SYNC_STAGES)) u_sync_raw (
    .clk(clk), .rst_n(rst_n), .d(raw_in), .level(raw_s), .rise(raw_edge_unused)
  );

  logic raw_event, sample;
  assign raw_event = enable & strobe_rise;
  assign sample    = raw_event & ~health_fail;

  // Health test: rep_cnt == 0 marks "no previous sample".
  logic [REP_CNT_W-1:0] rep_cnt, rep_next;
  logic                 raw_last;

  always_comb begin
    if (rep_cnt == '0 || raw_s != raw_last)
      rep_next = REP_CNT_W'(1);
    else if (rep_cnt >= REP_CNT_W'(REP_LIMIT))
      rep_next = rep_cnt;
    else
      rep_next = rep_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt     <= '0;
      raw_last    <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      if (clear_err || !enable)
        rep_cnt <= '0;
      else if (raw_event) begin
        rep_cnt  <= rep_next;
        raw_last <= raw_s;
      end
      if (clear_err)
        health_fail <= 1'b0;
      else if (raw_event && rep_next >= REP_CNT_W'(REP_LIMIT))
        health_fail <= 1'b1;
    end
  end

  // Von Neumann pair FSM
  pair_e pair_q, pair_d;
  logic  pair_clr, acc_valid, acc_bit;

  // Pair state only lives while debiasing, so debias_en=0 also covers a toggle.
  assign pair_clr = ~enable | health_fail | ~debias_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pair_q <= PAIR_EMPTY;
    else        pair_q <= pair_d;
  end

  always_comb begin
    pair_d = pair_q;
    if (pair_clr)
      pair_d = PAIR_EMPTY;
    else if (sample) begin
      case (pair_q)
        PAIR_EMPTY: pair_d = raw_s ? PAIR_HAVE1 : PAIR_HAVE0;
        default:    pair_d = PAIR_EMPTY;
      endcase
    end
  end

  always_comb begin
    acc_valid = 1'b0;
    acc_bit   = raw_s;
    if (sample) begin
      if (!debias_en)
        acc_valid = 1'b1;
      else begin
        case (pair_q)
          PAIR_HAVE1: begin acc_valid = ~raw_s; acc_bit = 1'b1; end
          PAIR_HAVE0: begin acc_valid = raw_s;  acc_bit = 1'b0; end
          default:    acc_valid = 1'b0;
        endcase
      end
    end
  end

  // Packer
  logic [WIDTH-2:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] word;
  logic             word_done, accept, load;

  assign word      = {shreg, acc_bit};
  assign word_done = acc_valid && (bit_cnt == CW'(WIDTH-1));
  assign accept    = out_if.valid & out_if.ready;
  assign load      = word_done & (~out_if.valid | out_if.ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (!enable || health_fail) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (acc_valid) begin
      if (word_done) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else begin
        shreg   <= word[WIDTH-2:0];
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Output register and handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_if.valid <= 1'b0;
      out_if.data  <= '0;
      overrun      <= 1'b0;
    end else begin
      if (load) begin
        out_if.valid <= 1'b1;
        out_if.data  <= word;
      end else if (accept)
        out_if.valid <= 1'b0;
      if (clear_err)
        overrun <= 1'b0;
      else if (word_done && !load)
        overrun <= 1'b1;
    end
  end

endmodule
